// File: rtl/aud_dsp.sv
// Sample-rate shaping stage ahead of the I2S DAC player: fetches PCM from SRAM once per
// LRCK period and emits normal, fast, slow-repeat or slow-interpolated samples.
module aud_dsp (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  input  logic        i_fast,
  input  logic        i_slow_0,
  input  logic        i_slow_1,
  input  logic [2:0]  i_speed,
  input  logic        i_daclrck,
  input  logic [19:0] i_end_addr,
  output logic [19:0] o_sram_addr,
  input  logic [15:0] i_sram_data,
  output logic [15:0] o_dac_data,
  output logic        o_en,
  output logic        o_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_CAPTURE, S_CALC, S_PAUSE
  } state_t;

  typedef enum logic [1:0] {M_NORM, M_FAST, M_REP, M_INT} mode_t;

  state_t             state, state_n;
  mode_t              mode_q, mode_in, mode_e;
  logic [2:0]         nm1_q, nm1_in, nm1_e;
  logic               lrck_q;
  logic [19:0]        addr;
  logic               ovf;
  logic [2:0]         k;
  logic signed [15:0] prev, cur, dac;

  logic [3:0]         n_e, step;
  logic [20:0]        addr_sum;
  logic               past_end, lrck_fall, k_last;
  logic signed [16:0] diff;
  logic signed [19:0] prod, n_s, quot;
  logic signed [15:0] interp;

  // Mode and rate come straight from the pins at the start of a sample (k == 0),
  // otherwise from the copy latched when that sample began.
  always_comb begin
    mode_in = M_NORM;
    if (i_fast)        mode_in = M_FAST;
    else if (i_slow_1) mode_in = M_INT;
    else if (i_slow_0) mode_in = M_REP;
    nm1_in   = (mode_in == M_NORM) ? 3'd0 : i_speed;
    mode_e   = (k == 3'd0) ? mode_in : mode_q;
    nm1_e    = (k == 3'd0) ? nm1_in : nm1_q;
    n_e      = {1'b0, nm1_e} + 4'd1;
    step     = (mode_e == M_REP || mode_e == M_INT) ? 4'd1 : n_e;
    addr_sum = {1'b0, addr} + {17'd0, step};
    past_end = ovf || (addr > i_end_addr);
    lrck_fall = lrck_q && !i_daclrck;
    k_last   = (k == nm1_e);
    diff     = {cur[15], cur} - {prev[15], prev};
    prod     = 20'(diff) * $signed({17'd0, k});
    n_s      = $signed({16'd0, n_e});
    quot     = prod / n_s;
    interp   = prev + quot[15:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (i_start) state_n = S_WAIT;
      S_WAIT: begin
        if (i_pause)        state_n = S_PAUSE;
        else if (lrck_fall) state_n = (k == 3'd0) ? S_FETCH : S_CALC;
      end
      S_FETCH:   state_n = S_CAPTURE;
      S_CAPTURE: state_n = past_end ? S_IDLE : S_CALC;
      S_CALC:    state_n = i_pause ? S_PAUSE : S_WAIT;
      S_PAUSE:   if (i_start && !i_pause) state_n = S_WAIT;
      default:   state_n = S_IDLE;
    endcase
    if (i_stop) state_n = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      lrck_q <= 1'b0;
      addr   <= '0;
      ovf    <= 1'b0;
      k      <= '0;
      prev   <= '0;
      cur    <= '0;
      dac    <= '0;
      mode_q <= M_NORM;
      nm1_q  <= '0;
    end else begin
      state  <= state_n;
      lrck_q <= i_daclrck;
      if (state_n == S_IDLE) begin
        addr   <= '0;
        ovf    <= 1'b0;
        k      <= '0;
        prev   <= '0;
        cur    <= '0;
        dac    <= '0;
        mode_q <= M_NORM;
        nm1_q  <= '0;
      end else if (state == S_CAPTURE) begin
        prev <= cur;
        cur  <= i_sram_data;
      end else if (state == S_CALC) begin
        if (k == 3'd0) begin
          mode_q <= mode_in;
          nm1_q  <= nm1_in;
        end
        if (mode_e == M_NORM || mode_e == M_FAST) begin
          dac  <= cur;
          addr <= addr_sum[19:0];
          ovf  <= ovf | addr_sum[20];
        end else begin
          dac <= (mode_e == M_INT) ? interp : cur;
          if (k_last) begin
            k    <= '0;
            addr <= addr_sum[19:0];
            ovf  <= ovf | addr_sum[20];
          end else begin
            k <= k + 3'd1;
          end
        end
      end
    end
  end

  // Done and enable are combinational on state so a past-end CAPTURE drops o_en in the same cycle.
  assign o_done      = (state == S_CAPTURE) && past_end;
  assign o_en        = (state == S_WAIT) || (state == S_FETCH) || (state == S_CALC) ||
                       ((state == S_CAPTURE) && !past_end);
  assign o_dac_data  = (state == S_PAUSE || state == S_IDLE) ? 16'd0 : dac;
  assign o_sram_addr = addr;
  assign dbg_state   = state;

endmodule

// File: tb/tb_aud_dsp.sv
// Bench for aud_dsp: behavioural SRAM and LRCK source, expected samples queued per test and
// compared at each LRCK rising edge where the player would latch them.
module tb_aud_dsp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
  logic        i_fast = 1'b0, i_slow_0 = 1'b0, i_slow_1 = 1'b0;
  logic [2:0]  i_speed = 3'd0;
  logic [19:0] i_end_addr = 20'd0;
  logic [19:0] o_sram_addr;
  logic [15:0] i_sram_data, o_dac_data;
  logic        o_en, o_done;
  logic [2:0]  dbg_state;
  logic        lrck;
  logic [4:0]  lrck_cnt = 5'd0;
  logic        lrck_mon = 1'b0;

  logic [15:0] mem [0:31];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out = 0;

  always #5 clk = ~clk;
  always @(posedge clk) lrck_cnt <= lrck_cnt + 5'd1;
  assign lrck        = lrck_cnt[4];
  assign i_sram_data = mem[o_sram_addr[4:0]];

  aud_dsp dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .i_fast(i_fast), .i_slow_0(i_slow_0), .i_slow_1(i_slow_1), .i_speed(i_speed),
    .i_daclrck(lrck), .i_end_addr(i_end_addr), .o_sram_addr(o_sram_addr),
    .i_sram_data(i_sram_data), .o_dac_data(o_dac_data), .o_en(o_en), .o_done(o_done),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] interp_model(int p, int c, int kk, int n);
    int d;
    d = (c - p) * kk;
    if (d < 0) d = -((-d) / n);
    else       d = d / n;
    return 16'(p + d);
  endfunction

  // Player-side sampling: one value per LRCK rise while enabled.
  always @(negedge clk) begin
    if (lrck && !lrck_mon && o_en) begin
      if (exp_q.size() == 0) check("extra_out", exp_q.size(), 1);
      else begin
        check("dac", {16'd0, o_dac_data}, {16'd0, exp_q.pop_front()});
        n_out++;
      end
    end
    lrck_mon = lrck;
  end

  task automatic start_pulse();
    @(negedge clk iff lrck_cnt == 5'd17);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!o_done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", {31'd0, o_done}, 1);
    check("en_at_done", {31'd0, o_en}, 0);
    @(negedge clk);
    check("done_width", {31'd0, o_done}, 0);
    check("en_after_done", {31'd0, o_en}, 0);
    check("leftover", exp_q.size(), 0);
  endtask

  task automatic wait_outputs(input int target);
    int c = 0;
    while (n_out < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("out_timeout", {31'd0, n_out >= target}, 1);
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 32; a++) mem[a] = 16'(a * 3);
  endtask

  initial begin
    int base;
    fill_ramp();
    repeat (3) @(negedge clk);
    check("rst_dac", {16'd0, o_dac_data}, 0);
    check("rst_addr", {12'd0, o_sram_addr}, 0);
    check("rst_en", {31'd0, o_en}, 0);
    check("rst_done", {31'd0, o_done}, 0);
    rst = 1'b0;

    // Normal: speed ignored, N forced to 1
    i_speed = 3'd5; i_end_addr = 20'd4;
    for (int a = 0; a <= 4; a++) exp_q.push_back(16'(a * 3));
    start_pulse();
    wait_done();

    // Fast N=3
    i_fast = 1'b1; i_speed = 3'd2; i_end_addr = 20'd9;
    for (int a = 0; a <= 9; a += 3) exp_q.push_back(16'(a * 3));
    start_pulse();
    wait_done();
    i_fast = 1'b0;

    // Slow repeat N=4: 20 periods for 5 samples
    i_slow_0 = 1'b1; i_speed = 3'd3; i_end_addr = 20'd4;
    for (int a = 0; a <= 4; a++)
      for (int r = 0; r < 4; r++) exp_q.push_back(16'(a * 3));
    base = n_out;
    start_pulse();
    wait_done();
    check("rep_count", n_out - base, 20);
    i_slow_0 = 1'b0;

    // Slow interpolation N=4, then a truncation-toward-zero case
    i_slow_1 = 1'b1; i_speed = 3'd3; i_end_addr = 20'd1;
    mem[0] = 16'd100; mem[1] = 16'hFF9C;
    for (int kk = 0; kk < 4; kk++) exp_q.push_back(interp_model(0, 100, kk, 4));
    for (int kk = 0; kk < 4; kk++) exp_q.push_back(interp_model(100, -100, kk, 4));
    start_pulse();
    wait_done();
    mem[0] = 16'd0; mem[1] = 16'hFFF9;
    for (int kk = 0; kk < 4; kk++) exp_q.push_back(interp_model(0, 0, kk, 4));
    for (int kk = 0; kk < 4; kk++) exp_q.push_back(interp_model(0, -7, kk, 4));
    start_pulse();
    wait_done();
    i_slow_1 = 1'b0;
    fill_ramp();

    // Pause after the third sample for 10 LRCK periods, then resume
    i_speed = 3'd0; i_end_addr = 20'd7;
    for (int a = 0; a <= 7; a++) exp_q.push_back(16'(a * 3));
    base = n_out;
    start_pulse();
    wait_outputs(base + 3);
    @(negedge clk iff lrck_cnt == 5'd17);
    i_pause = 1'b1;
    for (int p = 0; p < 10; p++) begin
      @(negedge clk iff lrck_cnt == 5'd20);
      check("pause_en", {31'd0, o_en}, 0);
      check("pause_dac", {16'd0, o_dac_data}, 0);
    end
    i_pause = 1'b0;
    start_pulse();
    wait_done();

    // Stop together with start mid-play
    i_end_addr = 20'd7;
    for (int a = 0; a <= 7; a++) exp_q.push_back(16'(a * 3));
    base = n_out;
    start_pulse();
    wait_outputs(base + 2);
    @(negedge clk iff lrck_cnt == 5'd2);
    i_stop = 1'b1; i_start = 1'b1;
    @(negedge clk);
    check("stop_en", {31'd0, o_en}, 0);
    check("stop_addr", {12'd0, o_sram_addr}, 0);
    check("stop_dac", {16'd0, o_dac_data}, 0);
    @(negedge clk);
    i_stop = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("stop_idle_en", {31'd0, o_en}, 0);
    exp_q.delete();

    // Asynchronous reset in the CAPTURE cycle, then a clean restart from SRAM[0]
    for (int a = 0; a <= 7; a++) exp_q.push_back(16'(a * 3));
    base = n_out;
    start_pulse();
    wait_outputs(base + 2);
    begin
      int c = 0;
      while (dbg_state != 3'd3 && c < 200) begin
        @(negedge clk);
        c++;
      end
      check("capture_seen", {29'd0, dbg_state}, 3);
    end
    rst = 1'b1;
    #1;
    check("arst_en", {31'd0, o_en}, 0);
    check("arst_done", {31'd0, o_done}, 0);
    check("arst_dac", {16'd0, o_dac_data}, 0);
    check("arst_addr", {12'd0, o_sram_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    i_end_addr = 20'd4;
    for (int a = 0; a <= 4; a++) exp_q.push_back(16'(a * 3));
    start_pulse();
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
